// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-unit definitions: bus width defaults, FSM state encoding
// and the wait-timer limit helper used by the fetch FSM and its timer.
package instr_fetch_unit_pkg;

    localparam int ADDR_W_DEF   = 16;
    localparam int DATA_W_DEF   = 16;
    localparam int WAIT_MAX_DEF = 15;
    localparam int CNT_W        = 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } fetch_state_e;

    // Last counter value allowed in WAIT before the fetch is abandoned.
    function automatic logic [CNT_W-1:0] wait_limit(input int wait_max);
        int lim;
        lim = wait_max - 1;
        return lim[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_wait_timer.sv
// Clear/enable wait-cycle counter for the fetch FSM.
// expired is high while the count sits on the last allowed WAIT cycle.
module fetch_wait_timer
    import instr_fetch_unit_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic Clock,
    input  logic Reset_n,
    input  logic clear,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] count;

    assign expired = (count == wait_limit(WAIT_MAX));

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: captures PC, runs a handshaked memory read,
// latches the word into IR and strobes pcd once per completed fetch.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] PC_out,
    input  logic              fetch_req,
    input  logic              flush,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] IR_out,
    output logic              pcd,
    output logic              fetch_done,
    output logic              fetch_err,
    output logic              busy
);

    fetch_state_e state, state_nxt;

    logic start;
    logic ir_load;
    logic tmr_clear;
    logic tmr_en;
    logic tmr_expired;

    fetch_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_timer (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .clear   (tmr_clear),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        ir_load   = 1'b0;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (fetch_req && !flush) begin
                    start     = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                tmr_clear = 1'b1;
                state_nxt = flush ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                // Flush beats a same-cycle ready; the read data is dropped.
                if (flush) begin
                    state_nxt = S_IDLE;
                end else if (mem_ready) begin
                    ir_load   = 1'b1;
                    state_nxt = S_DONE;
                end else if (tmr_expired) begin
                    state_nxt = S_ERR;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            mem_addr <= '0;
        end else if (start) begin
            mem_addr <= PC_out;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            IR_out <= '0;
        end else if (ir_load) begin
            IR_out <= mem_rdata;
        end
    end

    // Combinational so a jump arriving in DONE suppresses the increment.
    assign fetch_done = (state == S_DONE) && !flush;
    assign pcd        = fetch_done;
    assign fetch_err  = (state == S_ERR);
    assign mem_rd_en  = (state == S_REQ) || (state == S_WAIT);
    assign busy       = (state != S_IDLE);

endmodule
